muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage of the pipelined MIPS core; implements MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- Owns the architectural HI/LO registers and feeds MFHI/MFLO results into the EX/MEM pipeline register.
- Its busy output drives the hazard logic, which stalls IF/ID and clears ID/EX while an operation is in flight.

Parameters:
- ITERS, 32, iterations per operation; one operand bit per cycle. Fixed to 32 for 32-bit operands.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin operation; sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  32  rs operand: multiplicand or dividend
- b  in  32  rt operand: multiplier or divisor
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  32  MTHI/MTLO data
- hi  out  32  current HI
- lo  out  32  current LO
- busy  out  1  operation in flight (registered)
- done  out  1  one-cycle completion pulse (registered)

Behaviour:
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, iteration counter=0.
- Reset is asynchronous and aborts any operation in flight. HI/LO return to 0 and no done pulse is issued.
- States:
  - IDLE: start=1 at edge E0 latches op, |a|, |b| and the operand signs (for signed ops), clears the accumulator and counter, sets busy, and goes to RUN.
  - RUN: one iteration per cycle; counter increments; after 32 iterations (edge E32) goes to FIX.
  - FIX: applies sign correction. At edge E33 writes HI/LO, clears busy, sets done, and goes to IDLE.
- Latency: busy=1 for exactly 33 cycles after E0. New HI/LO values and done=1 are visible in the cycle after E33. done drops at the next edge.
- Multiply: shift-add over a 64-bit product.
  - HI = product[63:32], LO = product[31:0].
  - Signed result is negated when sign(a) != sign(b).
- Divide: restoring division with a 33-bit partial remainder.
  - LO = quotient, HI = remainder.
  - Signed: quotient is negated when signs differ; remainder takes the sign of the dividend.
- Boundary cases:
  - Divide by zero, b=0: no sign fix. LO=32'hFFFFFFFF, HI=a, for both DIV and DIVU.
  - DIV 32'h80000000 / 32'hFFFFFFFF: LO=32'h80000000, HI=0. Wraps, no trap.
  - MULT 32'h80000000 * 32'h80000000: HI=32'h40000000, LO=0.
- start while busy=1: ignored; operands are not re-latched.
- hi_we/lo_we:
  - Honoured only when busy=0 and the state is IDLE; ignored while busy.
  - Take effect at the same edge.
  - If asserted together with start, the write lands at E0 and is overwritten at E33.
- hi/lo outputs hold their values throughout an operation, so MFHI/MFLO issued before start reads the old values.
- Writes to hi and lo are independent; simultaneous hi_we and lo_we update both.

Optional Feature:
- Macro: MULDIV_FAST_MULT_EN.
- Defined:
  - MULT/MULTU use a single-cycle 32x32 signed/unsigned product.
  - start at E0 sets busy for 1 cycle; HI/LO are written and done is set at E1.
  - DIV/DIVU are unchanged at 33 cycles.
- Undefined: all ops use the 33-cycle iterative path described above.

Test Plan:
- MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> busy for 33 cycles, then HI=32'hFFFFFFFE, LO=32'h00000001, done pulse exactly 1 cycle.
- MULT a=-7 (32'hFFFFFFF9), b=6 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFD6. Repeat with MULT 32'h80000000 * 32'h80000000 -> HI=32'h40000000, LO=0.
- DIV a=-7, b=2 -> LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1). DIVU a=100, b=7 -> LO=14, HI=2.
- DIVU a=123, b=0 -> LO=32'hFFFFFFFF, HI=123. DIV 32'h80000000 / -1 -> LO=32'h80000000, HI=0.
- MTHI wdata=32'hA5A5A5A5 while idle -> hi updates next cycle. Start a DIV, assert start again plus lo_we mid-operation -> both ignored; final HI/LO come from the first operation only.
- Start MULT, assert reset at cycle 10 -> busy=0, hi=lo=0, done never pulses. A new MULTU 3*5 then yields LO=15, HI=0. With MULDIV_FAST_MULT_EN, MULTU 3*5 -> busy for 1 cycle, LO=15 one cycle after start.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Handshake and data bundle between the EX-stage control and muldiv_unit.
//   master : issues start/op/a/b and MTHI/MTLO writes, reads hi/lo/busy/done
//   slave  : the multiply/divide unit itself
// Signals:
//   start     begin operation (sampled only when the unit is idle)
//   op        00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b      rs / rt operands
//   hi_we     MTHI write enable
//   lo_we     MTLO write enable
//   wdata     MTHI/MTLO data
//   hi, lo    architectural HI/LO
//   busy      operation in flight
//   done      one-cycle completion pulse
interface muldiv_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage. Implements MULT, MULTU,
// DIV, DIVU, MTHI and MTLO and owns the architectural HI/LO registers.
// Multiply is shift-add over a 64-bit product; divide is restoring division
// on operand magnitudes, with the sign correction applied in a final cycle.
//
// Ports:
//   clock   system clock, rising edge
//   reset   asynchronous, active-high; aborts any operation in flight
//   bus     muldiv_unit_if.slave (start/op/a/b, hi_we/lo_we/wdata, hi/lo/busy/done)
//
// Build option:
//   MULDIV_FAST_MULT_EN  when defined, MULT/MULTU use a single-cycle 32x32
//                        product (busy for one cycle); DIV/DIVU stay iterative.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; MTHI/MTLO writes accepted here only
// RUN   | one operand bit per cycle, ITERS iterations
// FIX   | sign correction, HI/LO written, done pulsed
module muldiv_unit #(
    parameter int ITERS = 32
) (
    input  logic         clock,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(ITERS + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic             div_zero_q, div_zero_d;
    logic [31:0]      a_mag_q, a_mag_d;
    logic [31:0]      b_mag_q, b_mag_d;
    logic [63:0]      acc_q, acc_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Operand conditioning at start: op[0]=0 selects the signed variants.
    logic        signed_in;
    logic [31:0] a_mag_in;
    logic [31:0] b_mag_in;

    assign signed_in = ~bus.op[0];
    assign a_mag_in  = (signed_in && bus.a[31]) ? -bus.a : bus.a;
    assign b_mag_in  = (signed_in && bus.b[31]) ? -bus.b : bus.b;

    // Multiply step: acc = {partial product high, multiplier shifting out}.
    logic [32:0] mul_sum;
    assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_mag_q} : 33'd0);

    // Divide step: acc = {remainder, dividend shifting into quotient}.
    // When the subtraction succeeds the result is below the divisor, so the
    // low 32 bits of the difference are exact.
    logic [32:0] rem_shift;
    logic        rem_ge;
    logic [31:0] rem_sub;
    assign rem_shift = {acc_q[63:32], acc_q[31]};
    assign rem_ge    = (rem_shift >= {1'b0, b_mag_q});
    assign rem_sub   = rem_shift[31:0] - b_mag_q;

    // Sign correction on the finished magnitudes.
    logic        neg_res;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] a_orig;
    assign neg_res  = sign_a_q ^ sign_b_q;
    assign prod_fix = neg_res ? -acc_q : acc_q;
    assign quo_fix  = neg_res ? -acc_q[31:0] : acc_q[31:0];
    assign rem_fix  = sign_a_q ? -acc_q[63:32] : acc_q[63:32];
    // Divide by zero returns the dividend as given, rebuilt from sign+magnitude.
    assign a_orig   = sign_a_q ? -a_mag_q : a_mag_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= 2'b00;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            div_zero_q <= 1'b0;
            a_mag_q    <= '0;
            b_mag_q    <= '0;
            acc_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            div_zero_q <= div_zero_d;
            a_mag_q    <= a_mag_d;
            b_mag_q    <= b_mag_d;
            acc_q      <= acc_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        div_zero_d = div_zero_q;
        a_mag_d    = a_mag_q;
        b_mag_d    = b_mag_q;
        acc_d      = acc_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.hi_we) hi_d = bus.wdata;
                if (bus.lo_we) lo_d = bus.wdata;
                if (bus.start) begin
                    op_d       = bus.op;
                    sign_a_d   = signed_in & bus.a[31];
                    sign_b_d   = signed_in & bus.b[31];
                    div_zero_d = (bus.b == 32'd0);
                    a_mag_d    = a_mag_in;
                    b_mag_d    = b_mag_in;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = RUN;
                    acc_d      = bus.op[1] ? {32'd0, a_mag_in} : {32'd0, b_mag_in};
`ifdef MULDIV_FAST_MULT_EN
                    if (!bus.op[1]) begin
                        acc_d   = 64'(a_mag_in) * 64'(b_mag_in);
                        state_d = FIX;
                    end
`endif
                end
            end

            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q[1]) begin
                    acc_d = {rem_ge ? rem_sub : rem_shift[31:0], acc_q[30:0], rem_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[31:1]};
                end
                if (cnt_q == CNT_W'(ITERS - 1)) state_d = FIX;
            end

            FIX: begin
                if (!op_q[1]) begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end else if (div_zero_q) begin
                    hi_d = a_orig;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        string       name;
    } exp_t;

    logic  clock;
    logic  reset;
    int    n_checks;
    int    n_pass;
    int    n_done;
    int    done_before;
    int    busy_cnt;
    logic  prev_done;
    exp_t  sb[$];
    exp_t  mon_e;

    muldiv_unit_if bus();

    muldiv_unit #(.ITERS(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference: plain SV arithmetic plus the architectural corner rules.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input string name);
        exp_t        r;
        longint      sp;
        logic [63:0] up;
        int          q;
        int          rm;
        r.name = name;
`ifdef MULDIV_FAST_MULT_EN
        r.lat = op[1] ? 33 : 1;
`else
        r.lat = 33;
`endif
        r.hi = '0;
        r.lo = '0;
        case (op)
            2'b00: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                r.hi = sp[63:32];
                r.lo = sp[31:0];
            end
            2'b01: begin
                up = {32'd0, a} * {32'd0, b};
                r.hi = up[63:32];
                r.lo = up[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    r.hi = a;
                    r.lo = 32'hFFFF_FFFF;
                end else if (op == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r.hi = 32'd0;
                    r.lo = 32'h8000_0000;
                end else if (op == 2'b10) begin
                    q  = $signed(a) / $signed(b);
                    rm = $signed(a) % $signed(b);
                    r.hi = rm;
                    r.lo = q;
                end else begin
                    r.hi = a % b;
                    r.lo = a / b;
                end
            end
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Issues one operation; returns at the negedge after the start edge.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string name, input logic hw = 1'b0, input logic [31:0] wd = 32'd0);
        int g;
        g = 0;
        @(negedge clock);
        while ((bus.busy || bus.done) && g < 100) begin
            @(negedge clock);
            g++;
        end
        sb.push_back(model(op, a, b, name));
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.hi_we = hw;
        bus.wdata = wd;
        @(negedge clock);
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clock);
            t++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    initial begin
        busy_cnt  = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                busy_cnt  = 0;
                prev_done = 1'b0;
            end else begin
                if (prev_done) check("done_one_cycle", {63'd0, bus.done}, 64'd0);
                if (bus.busy) busy_cnt++;
                if (bus.done) begin
                    n_done++;
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_done: got done hi=%h lo=%h, required no done",
                                 bus.hi, bus.lo);
                    end else begin
                        mon_e = sb.pop_front();
                        check({mon_e.name, "_hi"}, {32'd0, bus.hi}, {32'd0, mon_e.hi});
                        check({mon_e.name, "_lo"}, {32'd0, bus.lo}, {32'd0, mon_e.lo});
                        check({mon_e.name, "_busy_cycles"}, 64'(busy_cnt), 64'(mon_e.lat));
                    end
                    busy_cnt = 0;
                end
                prev_done = bus.done;
            end
        end
    end

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        n_done    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("reset_hi", {32'd0, bus.hi}, 64'd0);
        check("reset_lo", {32'd0, bus.lo}, 64'd0);
        check("reset_busy", {63'd0, bus.busy}, 64'd0);
        check("reset_done", {63'd0, bus.done}, 64'd0);

        bus.hi_we = 1'b1;
        bus.wdata = 32'hA5A5_A5A5;
        @(posedge clock); #1;
        check("mthi_hi", {32'd0, bus.hi}, 64'hA5A5_A5A5);
        check("mthi_lo_kept", {32'd0, bus.lo}, 64'd0);
        @(negedge clock);
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h5A5A_5A5A;
        @(posedge clock); #1;
        check("mtlo_lo", {32'd0, bus.lo}, 64'h5A5A_5A5A);
        check("mtlo_hi_kept", {32'd0, bus.hi}, 64'hA5A5_A5A5);
        @(negedge clock);
        bus.hi_we = 1'b1;
        bus.wdata = 32'h0F0F_0F0F;
        @(posedge clock); #1;
        check("mt_both_hi", {32'd0, bus.hi}, 64'h0F0F_0F0F);
        check("mt_both_lo", {32'd0, bus.lo}, 64'h0F0F_0F0F);
        @(negedge clock);
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;

        do_op(2'b11, 32'd100, 32'd7, "divu_100_7");
        repeat (10) @(negedge clock);
        check("hold_hi", {32'd0, bus.hi}, 64'h0F0F_0F0F);
        check("hold_lo", {32'd0, bus.lo}, 64'h0F0F_0F0F);
        wait_done();

        do_op(2'b11, 32'd1000, 32'd7, "divu_1000_7");
        repeat (5) @(negedge clock);
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.a     = 32'd5;
        bus.b     = 32'd5;
        bus.lo_we = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        @(negedge clock);
        bus.start = 1'b0;
        bus.lo_we = 1'b0;
        check("busy_lo_we_ignored", {32'd0, bus.lo}, 64'd14);
        check("busy_hi_held", {32'd0, bus.hi}, 64'd2);
        wait_done();

        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        wait_done();
        do_op(2'b00, 32'hFFFF_FFF9, 32'd6, "mult_m7_6", 1'b1, 32'h1111_1111);
        check("start_mthi_lands", {32'd0, bus.hi}, 64'h1111_1111);
        wait_done();
        do_op(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_min_sq");
        wait_done();
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        wait_done();
        do_op(2'b11, 32'd123, 32'd0, "divu_by0");
        wait_done();
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
        wait_done();
        do_op(2'b10, 32'hFFFF_FFFB, 32'd0, "div_neg_by0");
        wait_done();

        do_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, "mult_aborted");
        repeat (9) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("abort_hi", {32'd0, bus.hi}, 64'd0);
        check("abort_lo", {32'd0, bus.lo}, 64'd0);
        check("abort_busy", {63'd0, bus.busy}, 64'd0);
        sb.delete();
        done_before = n_done;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        check("abort_no_done", 64'(n_done), 64'(done_before));
        do_op(2'b01, 32'd3, 32'd5, "multu_3_5");
        wait_done();

        for (int i = 0; i < 40; i++) begin
            do_op(2'($urandom_range(0, 3)), rnd_operand(), rnd_operand(), "rand");
            wait_done();
        end

        repeat (3) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
